bp_be_stride_prefetch_issuer: RTL

Consumes the discovery events produced by the backend stride detector (start/confirm, striding PC, effective address, stride) and turns each confirmed stride into a short burst of prefetch requests. It sits between the stride detector and the data-cache prefetch port. It tracks up to `streams_p` active streams keyed by PC and issues requests through a single registered valid/ready output port.

---
 rtl/bp_be_stride_prefetch_issuer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bp_be_stride_prefetch_issuer.sv
// Turns confirmed stride-detector events into short prefetch bursts, tracking a small
// PC-keyed stream table and issuing through one registered valid/ready port.
module bp_be_stride_prefetch_issuer #(
  parameter int unsigned vaddr_width_p          = 39,
  parameter int unsigned stride_width_p         = 8,
  parameter int unsigned effective_addr_width_p = vaddr_width_p,
  parameter int unsigned streams_p              = 4,
  parameter int unsigned prefetch_depth_p       = 2
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic                              flush_i,
  input  logic                              start_discovery_i,
  input  logic                              confirm_discovery_i,
  input  logic [vaddr_width_p-1:0]          striding_pc_i,
  input  logic [effective_addr_width_p-1:0] eff_addr_i,
  input  logic [stride_width_p-1:0]         stride_i,
  output logic                              prefetch_v_o,
  output logic [effective_addr_width_p-1:0] prefetch_addr_o,
  input  logic                              prefetch_ready_and_i
);

  localparam int unsigned IdxW = $clog2(streams_p);
  localparam int unsigned EaW  = effective_addr_width_p;
  localparam int unsigned RemW = 3;

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [RemW-1:0] rem_t;

  localparam rem_t DepthRem = rem_t'(prefetch_depth_p);

  typedef enum logic {e_empty, e_full} state_e;

  state_e                   state_q, state_d;
  logic [streams_p-1:0]     v_q, v_d;
  logic [vaddr_width_p-1:0] pc_q        [streams_p];
  logic [vaddr_width_p-1:0] pc_d        [streams_p];
  logic [EaW-1:0]           next_addr_q [streams_p];
  logic [EaW-1:0]           next_addr_d [streams_p];
  logic [EaW-1:0]           stride_q    [streams_p];
  logic [EaW-1:0]           stride_d    [streams_p];
  rem_t                     rem_q       [streams_p];
  rem_t                     rem_d       [streams_p];
  idx_t                     victim_q, victim_d;
  idx_t                     last_q, last_d;
  logic [EaW-1:0]           addr_q, addr_d;

  logic [EaW-1:0] stride_ext;
  logic [EaW-1:0] first_addr;
  logic           hit, any_inv;
  idx_t           hit_idx, inv_idx;
  logic           confirm_act, start_act, write_en, evict;
  idx_t           wr_idx;
  logic           sel_found;
  idx_t           sel_idx, cand;
  logic           can_load, bypass;

  assign stride_ext = {{(EaW - stride_width_p){stride_i[stride_width_p-1]}}, stride_i};
  assign first_addr = eff_addr_i + stride_ext;

  // PC match and lowest-index free slot (descending scan so the lowest index wins).
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    any_inv = 1'b0;
    inv_idx = '0;
    for (int i = int'(streams_p) - 1; i >= 0; i--) begin
      if (v_q[i] && (pc_q[i] == striding_pc_i)) begin
        hit     = 1'b1;
        hit_idx = idx_t'(i);
      end
      if (!v_q[i]) begin
        any_inv = 1'b1;
        inv_idx = idx_t'(i);
      end
    end
  end

  always_comb begin
    confirm_act = ~flush_i & confirm_discovery_i & (stride_i != '0);
    start_act   = ~flush_i & start_discovery_i & ~confirm_discovery_i & hit;
    write_en    = confirm_act | start_act;
    evict       = confirm_act & ~hit & ~any_inv;
    wr_idx      = hit ? hit_idx : (any_inv ? inv_idx : victim_q);
  end

  // Round-robin pick starting one past the last-loaded entry; entries being written
  // this cycle are skipped so the table update always wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= int'(streams_p); k++) begin
      cand = last_q + idx_t'(k);
      if (!sel_found && v_q[cand] && (rem_q[cand] != '0) && !(write_en && (wr_idx == cand)))
      begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign can_load = (state_q == e_empty) | prefetch_ready_and_i;
  // An empty output takes a fresh confirm directly, giving next-cycle valid.
  assign bypass   = (state_q == e_empty) & confirm_act & ~sel_found;

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    pc_d        = pc_q;
    next_addr_d = next_addr_q;
    stride_d    = stride_q;
    rem_d       = rem_q;
    victim_d    = victim_q;
    last_d      = last_q;
    addr_d      = addr_q;

    if (flush_i) begin
      v_d     = '0;
      state_d = e_empty;
      addr_d  = '0;
    end else begin
      if (start_act) begin
        v_d[wr_idx] = 1'b0;
      end else if (confirm_act) begin
        v_d[wr_idx]         = 1'b1;
        pc_d[wr_idx]        = striding_pc_i;
        stride_d[wr_idx]    = stride_ext;
        next_addr_d[wr_idx] = first_addr;
        rem_d[wr_idx]       = DepthRem;
        if (evict) begin
          victim_d = victim_q + idx_t'(1);
        end
      end

      if (can_load) begin
        if (sel_found) begin
          addr_d               = next_addr_q[sel_idx];
          next_addr_d[sel_idx] = next_addr_q[sel_idx] + stride_q[sel_idx];
          rem_d[sel_idx]       = rem_q[sel_idx] - 3'd1;
          last_d               = sel_idx;
          state_d              = e_full;
        end else if (bypass) begin
          addr_d              = first_addr;
          next_addr_d[wr_idx] = first_addr + stride_ext;
          rem_d[wr_idx]       = DepthRem - 3'd1;
          last_d              = wr_idx;
          state_d             = e_full;
        end else begin
          addr_d  = '0;
          state_d = e_empty;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= e_empty;
      v_q      <= '0;
      victim_q <= '0;
      last_q   <= '0;
      addr_q   <= '0;
      for (int i = 0; i < int'(streams_p); i++) begin
        pc_q[i]        <= '0;
        next_addr_q[i] <= '0;
        stride_q[i]    <= '0;
        rem_q[i]       <= '0;
      end
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      victim_q    <= victim_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      pc_q        <= pc_d;
      next_addr_q <= next_addr_d;
      stride_q    <= stride_d;
      rem_q       <= rem_d;
    end
  end

  assign prefetch_v_o    = (state_q == e_full);
  assign prefetch_addr_o = addr_q;

endmodule
